lbdr_input_fifo: RTL and testbench

// - Per-port input buffer of the router; sits directly upstream of LBDR.
// - Stores incoming flits in a first-word-fall-through FIFO with credit-based flow control to the upstream router.
// - Presents empty, flit_id and dst_addr of the head flit to LBDR.
// - Checks packet framing (HEADER..TAIL) on the write side.

---
 rtl/lbdr_input_fifo_pkg.sv | 14 +
 rtl/lbdr_input_fifo.sv | 100 ++++++++++
 tb/tb_lbdr_input_fifo.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/lbdr_input_fifo_pkg.sv
// Shared router parameters: flit type encodings and the framing-state enum
// used by the LBDR input buffer.
package lbdr_input_fifo_pkg;

  localparam logic [2:0] FLIT_HEADER = 3'b001;
  localparam logic [2:0] FLIT_BODY   = 3'b010;
  localparam logic [2:0] FLIT_TAIL   = 3'b100;

  typedef enum logic {
    IDLE,
    IN_PKT
  } frame_state_t;

endpackage

// File: rtl/lbdr_input_fifo.sv
// Per-port FWFT input buffer ahead of LBDR: credit return to upstream,
// head-flit routing fields, sticky overflow/underflow/framing error flags.
module lbdr_input_fifo
  import lbdr_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] flit_in,
  output logic                  credit_out,
  input  logic                  read_en,
  output logic                  empty,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] flit_out,
  output logic [2:0]            flit_id,
  output logic [3:0]            dst_addr,
  output logic                  overflow_err,
  output logic                  underflow_err,
  output logic                  proto_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW-1:0] PTR_ONE  = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  rd_fire, wr_fire;
  logic [2:0]            in_id;
  frame_state_t          state, state_nxt;
  logic                  proto_hit;

  // Status flags come from the count register only, so LBDR never sees a
  // combinational path from valid_in/read_en.
  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign rd_fire  = read_en & ~empty;
  assign wr_fire  = valid_in & (~full | rd_fire);
  assign in_id    = flit_in[DATA_WIDTH-1 -: 3];

  assign flit_out = mem[rd_ptr];
  assign flit_id  = flit_out[DATA_WIDTH-1 -: 3];
  assign dst_addr = flit_out[3:0];

  // Storage has no reset; flit_out is don't-care while empty.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      credit_out    <= 1'b0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
      proto_err     <= 1'b0;
      state         <= IDLE;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_fire) rd_ptr <= rd_ptr + PTR_ONE;
      if (wr_fire && !rd_fire)      count <= count + CNT_ONE;
      else if (rd_fire && !wr_fire) count <= count - CNT_ONE;
      credit_out <= rd_fire;
      if (valid_in && full && !rd_fire) overflow_err  <= 1'b1;
      if (read_en && empty)             underflow_err <= 1'b1;
      if (proto_hit)                    proto_err     <= 1'b1;
      state <= state_nxt;
    end
  end

  // Framing check; erroneous flits are still stored.
  always_comb begin
    state_nxt = state;
    proto_hit = 1'b0;
    if (wr_fire) begin
      case (in_id)
        FLIT_HEADER: begin
          if (state == IDLE) state_nxt = IN_PKT;
          else               proto_hit = 1'b1;
        end
        FLIT_BODY: begin
          if (state == IDLE) proto_hit = 1'b1;
        end
        FLIT_TAIL: begin
          if (state == IDLE) proto_hit = 1'b1;
          else               state_nxt = IDLE;
        end
        default: proto_hit = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_lbdr_input_fifo.sv
// Directed scoreboard bench for lbdr_input_fifo: stimulus pushes accepted
// flits, a negedge monitor pops on every pop and checks credit timing.
module tb_lbdr_input_fifo;
  import lbdr_input_fifo_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic [DW-1:0] flit_in;
  logic          credit_out;
  logic          read_en;
  logic          empty, full;
  logic [DW-1:0] flit_out;
  logic [2:0]    flit_id;
  logic [3:0]    dst_addr;
  logic          overflow_err, underflow_err, proto_err;

  lbdr_input_fifo #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flit_in(flit_in),
    .credit_out(credit_out), .read_en(read_en), .empty(empty), .full(full),
    .flit_out(flit_out), .flit_id(flit_id), .dst_addr(dst_addr),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic          mon_on = 1'b0;
  logic          exp_credit = 1'b0;
  int            n_pops = 0;
  int            n_credits = 0;

  function automatic logic [DW-1:0] mk(input logic [2:0] id, input logic [3:0] src,
                                       input logic [3:0] dst, input logic [20:0] pl);
    return {id, pl, src, dst};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs for one cycle; returns at posedge+1 so flags can be checked.
  // push=1 means the bench expects this write to be accepted.
  task automatic step(input logic v, input logic [DW-1:0] f, input logic re, input logic push);
    valid_in = v;
    flit_in  = v ? f : '0;
    read_en  = re;
    if (push) exp_q.push_back(f);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; read_en = 1'b0; flit_in = '0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: credit_out must mirror the previous cycle's pop; each pop is
  // compared against the scoreboard head.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("credit_out", {31'b0, credit_out}, {31'b0, exp_credit});
      if (credit_out === 1'b1) n_credits++;
      exp_credit = read_en && !empty && !rst;
      if (read_en && !empty && !rst) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_unexpected: got %h expected no flit", flit_out);
        end else begin
          chk("flit_out", flit_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] f;
    do_reset();
    mon_on = 1'b1;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_errs", {29'b0, overflow_err, underflow_err, proto_err}, 32'd0);

    // HEADER(dst A), BODY, TAIL, then one more HEADER fills to DEPTH.
    step(1'b1, mk(FLIT_HEADER, 4'h3, 4'hA, 21'h1), 1'b0, 1'b1);
    chk("fwft_empty", {31'b0, empty}, 32'd0);
    chk("head_id", {29'b0, flit_id}, {29'b0, FLIT_HEADER});
    chk("head_dst", {28'b0, dst_addr}, 32'hA);
    step(1'b1, mk(FLIT_BODY, 4'h3, 4'h0, 21'h2), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_TAIL, 4'h3, 4'h0, 21'h3), 1'b0, 1'b1);
    chk("cnt3_not_full", {31'b0, full}, 32'd0);
    step(1'b1, mk(FLIT_HEADER, 4'h3, 4'h5, 21'h4), 1'b0, 1'b1);
    chk("full_after_4", {31'b0, full}, 32'd1);
    drain(4);
    chk("drained_empty", {31'b0, empty}, 32'd1);
    chk("credit_count", n_credits, n_pops);

    // Full plus simultaneous write/read, then write alone while full.
    step(1'b1, mk(FLIT_BODY, 4'h1, 4'h0, 21'h10), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_BODY, 4'h1, 4'h0, 21'h11), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_BODY, 4'h1, 4'h0, 21'h12), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_TAIL, 4'h1, 4'h0, 21'h13), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_HEADER, 4'h2, 4'h7, 21'h14), 1'b1, 1'b1);
    chk("simul_full", {31'b0, full}, 32'd1);
    chk("simul_no_ovf", {31'b0, overflow_err}, 32'd0);
    step(1'b1, mk(FLIT_BODY, 4'h2, 4'h0, 21'h15), 1'b0, 1'b0);
    chk("ovf_set", {31'b0, overflow_err}, 32'd1);
    drain(4);
    step(1'b1, mk(FLIT_TAIL, 4'h2, 4'h0, 21'h16), 1'b0, 1'b1);
    drain(1);
    chk("ovf_sticky", {31'b0, overflow_err}, 32'd1);
    chk("no_proto", {31'b0, proto_err}, 32'd0);
    chk("no_underflow", {31'b0, underflow_err}, 32'd0);

    // Framing and underflow errors.
    do_reset();
    chk("ovf_cleared", {31'b0, overflow_err}, 32'd0);
    step(1'b1, mk(FLIT_BODY, 4'h4, 4'h0, 21'h20), 1'b0, 1'b1);
    chk("proto_body_idle", {31'b0, proto_err}, 32'd1);
    drain(1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("underflow", {31'b0, underflow_err}, 32'd1);
    do_reset();
    step(1'b1, mk(FLIT_HEADER, 4'h4, 4'h1, 21'h21), 1'b0, 1'b1);
    chk("proto_h_ok", {31'b0, proto_err}, 32'd0);
    step(1'b1, mk(FLIT_HEADER, 4'h4, 4'h2, 21'h22), 1'b0, 1'b1);
    chk("proto_hh", {31'b0, proto_err}, 32'd1);
    drain(2);
    do_reset();
    step(1'b1, mk(3'b000, 4'h4, 4'h2, 21'h23), 1'b0, 1'b1);
    chk("proto_bad_id", {31'b0, proto_err}, 32'd1);
    drain(1);

    // Wrap-around: 10 flits with one-cycle read lag.
    do_reset();
    for (int i = 0; i <= 10; i++) begin
      f = mk(i == 0 ? FLIT_HEADER : (i == 9 ? FLIT_TAIL : FLIT_BODY), 4'h6, 4'(i), 21'(100 + i));
      step(i < 10, f, i >= 1, i < 10);
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk("wrap_empty", {31'b0, empty}, 32'd1);
    chk("wrap_sb_empty", exp_q.size(), 0);
    chk("wrap_clean", {29'b0, overflow_err, underflow_err, proto_err}, 32'd0);

    // Reset mid-packet flushes the FIFO and returns framing to IDLE.
    step(1'b1, mk(FLIT_HEADER, 4'h7, 4'h9, 21'h30), 1'b0, 1'b1);
    step(1'b1, mk(FLIT_BODY, 4'h7, 4'h0, 21'h31), 1'b0, 1'b1);
    rst = 1'b1; exp_q.delete();
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_full", {31'b0, full}, 32'd0);
    chk("mid_rst_credit", {31'b0, credit_out}, 32'd0);
    chk("mid_rst_errs", {29'b0, overflow_err, underflow_err, proto_err}, 32'd0);
    step(1'b1, mk(FLIT_HEADER, 4'h7, 4'hB, 21'h32), 1'b0, 1'b1);
    chk("mid_rst_fsm_idle", {31'b0, proto_err}, 32'd0);
    chk("mid_rst_head_dst", {28'b0, dst_addr}, 32'hB);
    drain(1);
    chk("final_sb_empty", exp_q.size(), 0);
    chk("final_credits", n_credits, n_pops);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
